// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - handshake and stage-enable bundle between datapath and sequencer
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             stop;
    logic             instr_ready;
    logic             mem_ready;
    logic             mem_access;
    logic             reg_write;
    logic             halt_instr;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             writeback_en;
    logic             pc_write;
    logic             rf_write_en;
    logic             busy;
    logic             halted;
    logic             error;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, stop, instr_ready, mem_ready, mem_access, reg_write, halt_instr,
        input  fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_write,
               rf_write_en, busy, halted, error, state, cycle_count, instr_count
    );

    modport slave (
        input  start, stop, instr_ready, mem_ready, mem_access, reg_write, halt_instr,
        output fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_write,
               rf_write_en, busy, halted, error, state, cycle_count, instr_count
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - single-clock LEGv8 stage sequencer; SEQ_PERF_COUNTERS_EN adds cycle/instr counters
module multicycle_sequencer #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter bit          SKIP_MEM   = 1'b1,
    parameter int unsigned MAX_INSTR  = 0,
    parameter int          CNT_W      = 32
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_sequencer_if.slave sbus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    localparam int WCNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = (WAIT_LIMIT == 0) ? '0 : WCNT_W'(WAIT_LIMIT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [WCNT_W-1:0] r_wait;
    logic [31:0]       r_retire;
    logic [31:0]       w_retire_next;
    logic              w_retire;
    logic              w_wait_hit;
    logic              r_fetch_en;
    logic              r_decode_en;
    logic              r_execute_en;
    logic              r_memory_en;
    logic              r_writeback_en;
    logic              r_busy;
    logic              r_halted;
    logic              r_error;

    // The retire counter saturates; the halt limit looks at the post-increment value.
    assign w_retire_next = (r_retire == 32'hFFFF_FFFF) ? r_retire : r_retire + 32'd1;
    // A ready arriving on the threshold cycle is checked first, so it wins over the timeout.
    assign w_wait_hit    = (WAIT_LIMIT != 0) && (r_wait == WAIT_LAST);

    // Next-state decision and retire strobe.
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:      if (sbus.start) w_next = S_FETCH;
            S_FETCH: begin
                if (sbus.instr_ready)  w_next = S_DECODE;
                else if (w_wait_hit)   w_next = S_ERROR;
            end
            S_DECODE: begin
                if (sbus.halt_instr) begin
                    w_next   = S_HALT;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE:   w_next = (sbus.mem_access || !SKIP_MEM) ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                if (sbus.mem_ready)    w_next = S_WRITEBACK;
                else if (w_wait_hit)   w_next = S_ERROR;
            end
            S_WRITEBACK: begin
                w_retire = 1'b1;
                if ((MAX_INSTR != 0) && (w_retire_next >= MAX_INSTR)) w_next = S_HALT;
                else if (sbus.stop)                                   w_next = S_IDLE;
                else                                                  w_next = S_FETCH;
            end
            S_HALT:      w_next = S_HALT;
            S_ERROR:     w_next = S_ERROR;
            default:     w_next = S_ERROR;
        endcase
    end

    // State, wait counter, retire counter and stage enables registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_wait         <= '0;
            r_retire       <= '0;
            r_fetch_en     <= 1'b0;
            r_decode_en    <= 1'b0;
            r_execute_en   <= 1'b0;
            r_memory_en    <= 1'b0;
            r_writeback_en <= 1'b0;
            r_busy         <= 1'b0;
            r_halted       <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (r_state == S_FETCH || r_state == S_MEMORY)
                r_wait <= r_wait + 1'b1;
            if (w_retire)
                r_retire <= w_retire_next;
            r_fetch_en     <= (w_next == S_FETCH);
            r_decode_en    <= (w_next == S_DECODE);
            r_execute_en   <= (w_next == S_EXECUTE);
            r_memory_en    <= (w_next == S_MEMORY);
            r_writeback_en <= (w_next == S_WRITEBACK);
            r_busy         <= (w_next != S_IDLE) && (w_next != S_HALT) && (w_next != S_ERROR);
            r_halted       <= (w_next == S_HALT);
            r_error        <= (w_next == S_ERROR);
        end
    end

    assign sbus.fetch_en     = r_fetch_en;
    assign sbus.decode_en    = r_decode_en;
    assign sbus.execute_en   = r_execute_en;
    assign sbus.memory_en    = r_memory_en;
    assign sbus.writeback_en = r_writeback_en;
    assign sbus.pc_write     = r_writeback_en;
    assign sbus.rf_write_en  = r_writeback_en & sbus.reg_write;
    assign sbus.busy         = r_busy;
    assign sbus.halted       = r_halted;
    assign sbus.error        = r_error;
    assign sbus.state        = r_state;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;

    // Saturating active-cycle and retired-instruction counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (r_busy && (r_cycle_count != {CNT_W{1'b1}}))
                r_cycle_count <= r_cycle_count + 1'b1;
            if (w_retire && (r_instr_count != {CNT_W{1'b1}}))
                r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign sbus.cycle_count = r_cycle_count;
    assign sbus.instr_count = r_instr_count;
`else
    assign sbus.cycle_count = '0;
    assign sbus.instr_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized instruction-level check of multicycle_sequencer
module tb_multicycle_sequencer;
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
                           MEMORY = 3'd4, WB = 3'd5, HALT = 3'd6, ERROR = 3'd7;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       instr_ready;
        logic       mem_ready;
        logic       mem_access;
        logic       reg_write;
        logic       halt_instr;
        logic [2:0] st;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    cyc_t tr[$];

    always #5 clk = ~clk;

    multicycle_sequencer_if #(.CNT_W(32)) bus_a ();
    multicycle_sequencer_if #(.CNT_W(32)) bus_b ();

    multicycle_sequencer #(.WAIT_LIMIT(4), .SKIP_MEM(1'b1), .MAX_INSTR(0), .CNT_W(32))
        u_dut_a (.clk(clk), .reset(reset), .sbus(bus_a));
    multicycle_sequencer #(.WAIT_LIMIT(4), .SKIP_MEM(1'b1), .MAX_INSTR(2), .CNT_W(32))
        u_dut_b (.clk(clk), .reset(reset), .sbus(bus_b));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] exp_flags(input logic [2:0] st, input logic rw);
        logic w;
        w = (st == WB);
        return {st == FETCH, st == DECODE, st == EXECUTE, st == MEMORY, w, w, w & rw,
                (st >= FETCH) && (st <= WB), st == HALT, st == ERROR, st};
    endfunction

    function automatic logic [63:0] perf(input int v);
`ifdef SEQ_PERF_COUNTERS_EN
        return 64'(v);
`else
        return 64'(v & 0);
`endif
    endfunction

    function automatic cyc_t rnd_cyc(input logic [2:0] st);
        logic [31:0] r;
        cyc_t c;
        r = $urandom;
        c = r[9:0];
        c.st = st;
        return c;
    endfunction

    task automatic drive(input cyc_t c);
        bus_a.start = c.start;           bus_b.start = c.start;
        bus_a.stop = c.stop;             bus_b.stop = c.stop;
        bus_a.instr_ready = c.instr_ready; bus_b.instr_ready = c.instr_ready;
        bus_a.mem_ready = c.mem_ready;   bus_b.mem_ready = c.mem_ready;
        bus_a.mem_access = c.mem_access; bus_b.mem_access = c.mem_access;
        bus_a.reg_write = c.reg_write;   bus_b.reg_write = c.reg_write;
        bus_a.halt_instr = c.halt_instr; bus_b.halt_instr = c.halt_instr;
    endtask

    task automatic check_dut(input string nm, input int k, input logic [2:0] st, input logic rw,
                             input int cyc, input int ins);
        logic [12:0] got;
        if (nm == "a")
            got = {bus_a.fetch_en, bus_a.decode_en, bus_a.execute_en, bus_a.memory_en,
                   bus_a.writeback_en, bus_a.pc_write, bus_a.rf_write_en, bus_a.busy,
                   bus_a.halted, bus_a.error, bus_a.state};
        else
            got = {bus_b.fetch_en, bus_b.decode_en, bus_b.execute_en, bus_b.memory_en,
                   bus_b.writeback_en, bus_b.pc_write, bus_b.rf_write_en, bus_b.busy,
                   bus_b.halted, bus_b.error, bus_b.state};
        check_val($sformatf("%s_flags[%0d]", nm, k), 64'(got), 64'(exp_flags(st, rw)));
        check_val($sformatf("%s_cycle_count[%0d]", nm, k),
                  (nm == "a") ? 64'(bus_a.cycle_count) : 64'(bus_b.cycle_count), perf(cyc));
        check_val($sformatf("%s_instr_count[%0d]", nm, k),
                  (nm == "a") ? 64'(bus_a.instr_count) : 64'(bus_b.instr_count), perf(ins));
    endtask

    // Builds one episode as a per-cycle list of {inputs, expected state} from the instruction plan.
    // ending: 0 stop, 1 halt instruction, 2 fetch timeout, 3 memory timeout; -1 picks at random.
    task automatic gen_episode(input int force_n, input int force_end);
        int n, ending, fw, mw;
        bit last, done, m;
        cyc_t c;
        logic [2:0] term;
        tr.delete();
        n      = (force_n > 0) ? force_n : int'($urandom_range(1, 4));
        ending = (force_end >= 0) ? force_end : int'($urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) begin
            c = rnd_cyc(IDLE); c.start = 1'b0; tr.push_back(c);
        end
        c = rnd_cyc(IDLE); c.start = 1'b1; tr.push_back(c);
        done = 1'b0;
        for (int i = 0; i < n && !done; i++) begin
            last = (i == n - 1);
            if (last && ending == 2) begin
                repeat (4) begin c = rnd_cyc(FETCH); c.instr_ready = 1'b0; tr.push_back(c); end
                done = 1'b1;
            end else begin
                fw = $urandom_range(0, 3);
                repeat (fw) begin c = rnd_cyc(FETCH); c.instr_ready = 1'b0; tr.push_back(c); end
                c = rnd_cyc(FETCH); c.instr_ready = 1'b1; tr.push_back(c);
                c = rnd_cyc(DECODE); c.halt_instr = last && ending == 1; tr.push_back(c);
                if (last && ending == 1) begin
                    done = 1'b1;
                end else begin
                    m = (last && ending == 3) ? 1'b1 : 1'($urandom);
                    c = rnd_cyc(EXECUTE); c.mem_access = m; tr.push_back(c);
                    if (m && last && ending == 3) begin
                        repeat (4) begin c = rnd_cyc(MEMORY); c.mem_ready = 1'b0; tr.push_back(c); end
                        done = 1'b1;
                    end else begin
                        if (m) begin
                            mw = $urandom_range(0, 3);
                            repeat (mw) begin c = rnd_cyc(MEMORY); c.mem_ready = 1'b0; tr.push_back(c); end
                            c = rnd_cyc(MEMORY); c.mem_ready = 1'b1; tr.push_back(c);
                        end
                        c = rnd_cyc(WB); c.stop = last; tr.push_back(c);
                    end
                end
            end
        end
        term = (ending == 0) ? IDLE : (ending == 1) ? HALT : ERROR;
        repeat (3) begin
            c = rnd_cyc(term);
            if (term == IDLE) c.start = 1'b0;
            tr.push_back(c);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_dut({"a_", tag} == "a_" ? "a" : "a", -1, IDLE, 1'b0, 0, 0);
        check_dut("b", -1, IDLE, 1'b0, 0, 0);
    endtask

    // Replays an episode on both DUTs; B follows A until its second retire, then sits in HALT.
    task automatic run_episode(input bit allow_cut);
        int ea_cyc, ea_ins, eb_cyc, eb_ins, b_ret, cut_k;
        bit b_halt, busy_a, busy_b, ret_a, ret_b;
        logic [2:0] st, bst;
        @(negedge clk);
        drive('0);
        reset = 1'b1;
        #1;
        check_reset_state("rst");
        @(negedge clk);
        reset = 1'b0;
        cut_k = -1;
        if (allow_cut)
            foreach (tr[k]) if (cut_k < 0 && tr[k].st == MEMORY) cut_k = k;
        ea_cyc = 0; ea_ins = 0; eb_cyc = 0; eb_ins = 0; b_ret = 0; b_halt = 1'b0;
        for (int k = 0; k < tr.size(); k++) begin
            @(negedge clk);
            drive(tr[k]);
            #1;
            st  = tr[k].st;
            bst = b_halt ? HALT : st;
            check_dut("a", k, st, tr[k].reg_write, ea_cyc, ea_ins);
            check_dut("b", k, bst, tr[k].reg_write, eb_cyc, eb_ins);
            if (k == cut_k) begin
                #2;
                reset = 1'b1;
                #1;
                check_reset_state("midrst");
                break;
            end
            busy_a = (st >= FETCH) && (st <= WB);
            busy_b = (bst >= FETCH) && (bst <= WB);
            ret_a  = (st == WB) || (st == DECODE && tr[k].halt_instr);
            ret_b  = (bst == WB) || (bst == DECODE && tr[k].halt_instr);
            ea_cyc += int'(busy_a);
            ea_ins += int'(ret_a);
            eb_cyc += int'(busy_b);
            if (!b_halt && ret_b) begin
                eb_ins++;
                b_ret++;
                if (bst == WB && b_ret == 2) b_halt = 1'b1;
            end
        end
        if (cut_k >= 0) begin
            @(negedge clk);
            drive('0);
            reset = 1'b0;
            repeat (2) begin
                @(negedge clk);
                #1;
                check_dut("a", -2, IDLE, 1'b0, 0, 0);
            end
        end
    endtask

    initial begin
        drive('0);
        gen_episode(2, 0); run_episode(1'b0);
        gen_episode(1, 3); run_episode(1'b0);
        gen_episode(2, 2); run_episode(1'b0);
        gen_episode(3, 1); run_episode(1'b0);
        gen_episode(3, 0); run_episode(1'b1);
        for (int e = 0; e < 40; e++) begin
            gen_episode(-1, -1);
            run_episode(1'($urandom_range(0, 3) == 0));
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Single-clock stage sequencer for the LEGv8 multicycle core. Replaces the delayed-clock phase scheme (fetch/decode-read/memory/write phases) with one clock plus per-stage enables.
- Adds wait-state handshakes to instruction and data memory, a timeout error, a memory-stage skip, and an instruction-count halt.
- Sits between the top-level datapath and the Fetch/Decode/Execute/Memory/Writeback stages.

Parameters:
- WAIT_LIMIT, 16, max cycles a stage waits for a ready signal; 0 disables the timeout.
- SKIP_MEM, 1, 1 means non-memory instructions bypass the MEMORY state.
- MAX_INSTR, 0, retire limit that forces HALT; 0 means unlimited.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- stop  in  1  return to IDLE after the current instruction retires
- instr_ready  in  1  instruction memory holds valid data
- mem_ready  in  1  data memory access complete
- mem_access  in  1  decoded mem_read|mem_write for the current instruction
- reg_write  in  1  decoded register-write control
- halt_instr  in  1  decoded halt instruction
- fetch_en  out  1  fetch stage enable
- decode_en  out  1  register-file read enable
- execute_en  out  1  ALU/flag update enable
- memory_en  out  1  data memory enable
- writeback_en  out  1  writeback stage enable
- pc_write  out  1  PC update strobe
- rf_write_en  out  1  writeback_en & reg_write
- busy  out  1  state is not IDLE/HALT/ERROR
- halted  out  1  in HALT
- error  out  1  in ERROR (timeout)
- state  out  3  encoded state, for debug
- cycle_count  out  CNT_W  active cycles
- instr_count  out  CNT_W  retired instructions

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7.
- All enables are decodes of the registered state, so they are glitch-free.
- Each enable is high for every cycle spent in its state. pc_write is high only in WRITEBACK.
- Reset: state=IDLE. All outputs are 0, wait counter 0, retire counter 0, perf counters 0.
- Reset asserted mid-operation drops all enables immediately (asynchronous); no partial writeback occurs.
- IDLE: start=1 -> FETCH on the next edge; otherwise stay.
- FETCH:
  - instr_ready=1 -> DECODE.
  - Else stay and increment the wait counter.
  - Wait counter = WAIT_LIMIT-1 with ready still low (WAIT_LIMIT!=0) -> ERROR.
- DECODE: one cycle. halt_instr=1 -> HALT, and the halt counts as retired. Otherwise -> EXECUTE.
- EXECUTE: one cycle. -> MEMORY if mem_access=1 or SKIP_MEM=0; otherwise -> WRITEBACK.
- MEMORY: mem_ready=1 -> WRITEBACK. Otherwise wait, with the same timeout rule as FETCH.
- WRITEBACK: one cycle; retire counter +1. Next-state priority:
  1. MAX_INSTR reached -> HALT.
  2. stop=1 -> IDLE.
  3. Otherwise -> FETCH.
- Wait counter: clears on every state change. Width is clog2(WAIT_LIMIT+1), minimum 1 bit.
- A ready signal that arrives on the same cycle as the timeout threshold wins; the stage advances, no error.
- HALT and ERROR are sticky: start and stop are ignored, and only reset exits.
- stop is sampled only in WRITEBACK. start is sampled only in IDLE.
- Retire counter is 32 bits and saturates. MAX_INSTR compares against the post-increment value.
- Minimum instruction latency with ready held high: 4 cycles (F, D, E, W) when skipping memory, 5 cycles with memory. Each wait cycle adds 1.

Optional Feature:
- Macro: SEQ_PERF_COUNTERS_EN.
- Defined:
  - cycle_count increments each cycle busy=1.
  - instr_count increments each retire, including halt.
  - Both saturate at all-ones and clear only on reset.
- Undefined: cycle_count and instr_count are constant 0 and no counter flops are built. Sequencing is identical.

Test Plan:
- Reset, then start=1 for 1 cycle, ready lines held 1, mem_access=0: state sequence 0,1,2,3,5,1. pc_write high exactly 1 cycle per 4. With macro, instr_count=3 after 12 cycles.
- mem_access=1, mem_ready low for 3 cycles: memory_en high for 4 cycles, then WRITEBACK. rf_write_en high for 1 cycle when reg_write=1.
- WAIT_LIMIT=4, instr_ready held 0: ERROR after 4 FETCH cycles, error=1, busy=0. start is then ignored until reset.
- MAX_INSTR=2 with stop=1 asserted at the 2nd WRITEBACK: HALT, not IDLE. halted=1, instr_count=2.
- halt_instr=1 in DECODE: next state HALT, EXECUTE never entered, instr_count +1.
- Reset asserted while in MEMORY: all enables 0 in the same cycle, state=0. After release with start=0, remains IDLE.
